// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//
// Front-end conditioning for one push-button. The raw pad input is
// synchronised into the clk domain and debounced. Each debounced press is then
// classified as short or long, and the result is reported as single-cycle event
// pulses. The downstream controller therefore sees clean events, not raw levels.
//
// Parameters:
//   DEBOUNCE_COUNT   - consecutive cycles a new synchronised level must hold
//                      before btn_level follows it (>= 1)
//   LONG_PRESS_COUNT - debounced-high cycles that make a press "long" (>= 2)
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   btn_raw      in   asynchronous pad input, active-high
//   btn_level    out  debounced button level
//   press_pulse  out  one-cycle pulse on the debounced rising edge
//   short_pulse  out  one-cycle pulse on release of a press shorter than
//                     LONG_PRESS_COUNT
//   long_pulse   out  one-cycle pulse once a hold reaches LONG_PRESS_COUNT,
//                     issued while the button is still held
//
// Build option:
//   LONG_REPEAT_EN - when defined, long_pulse repeats every LONG_PRESS_COUNT
//                    cycles for as long as the button stays held. When it is
//                    undefined, exactly one long_pulse is issued per press.
//
// Timing (DEBOUNCE_COUNT = D, LONG_PRESS_COUNT = L):
//   btn_level follows btn_raw 2 + D cycles after the raw edge.
//   press_pulse is high in the cycle after btn_level rises.
//   long_pulse is high L cycles after btn_level rises. A debounced hold of
//   exactly L cycles is long, and a hold of L-1 cycles is short.
//   short_pulse is high in the cycle after btn_level falls.
// -----------------------------------------------------------------------------
module button_press_classifier #(
    parameter int DEBOUNCE_COUNT   = 1_000_000,
    parameter int LONG_PRESS_COUNT = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse
);

    // -------------------------------------------------------------------------
    // Local sizing
    // -------------------------------------------------------------------------
    localparam int SYNC_STAGES = 2;
    localparam int DEB_W       = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
    localparam int HOLD_W      = $clog2(LONG_PRESS_COUNT + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_sync;

    logic [DEB_W-1:0]       deb_cnt_reg;
    logic                   btn_level_reg;
    logic                   btn_level_d_reg;
    logic                   press_pulse_reg;

    state_t                 state_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [HOLD_W-1:0]      hold_cnt_next;
    logic                   short_pulse_reg;
    logic                   long_pulse_reg;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser. btn_raw is shifted in at bit 0, and the oldest
    // sample is the synchronised level.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_sync = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debouncer. deb_cnt_reg counts consecutive cycles in which the
    // synchronised input disagrees with the accepted level. Any agreement
    // resets the count, so a glitch must last a full DEBOUNCE_COUNT cycles to
    // be accepted. The level flips on the edge that sees the last count value,
    // which gives a total latency of 2 + DEBOUNCE_COUNT from the pad.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_cnt_reg   <= '0;
            btn_level_reg <= 1'b0;
        end else if (btn_sync == btn_level_reg) begin
            deb_cnt_reg   <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
            deb_cnt_reg   <= '0;
            btn_level_reg <= ~btn_level_reg;
        end else begin
            deb_cnt_reg   <= deb_cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Rising-edge detector on the debounced level. The pulse is registered.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_level_d_reg <= 1'b0;
            press_pulse_reg <= 1'b0;
        end else begin
            btn_level_d_reg <= btn_level_reg;
            press_pulse_reg <= btn_level_reg & ~btn_level_d_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating increment of the hold counter. The counter can never wrap,
    // even if a state path keeps counting past the long-press threshold.
    // -------------------------------------------------------------------------
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (hold_cnt_reg != HOLD_SAT) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Press classifier FSM. All pulse outputs are registered.
    //
    // The IDLE->PRESSED edge counts as the first held cycle. Each later
    // PRESSED cycle with the button still down advances hold_cnt_reg. The long
    // decision is taken on the edge where the count would reach L-1. A release
    // seen on that same edge takes the PRESSED/low branch instead, so release
    // wins at the boundary and the press is reported as short.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            hold_cnt_reg    <= '0;
            short_pulse_reg <= 1'b0;
            long_pulse_reg  <= 1'b0;
        end else begin
            short_pulse_reg <= 1'b0;
            long_pulse_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (btn_level_reg) begin
                        state_reg    <= ST_PRESSED;
                        hold_cnt_reg <= '0;
                    end
                end

                ST_PRESSED: begin
                    if (btn_level_reg) begin
                        hold_cnt_reg <= hold_cnt_next;
                        if (hold_cnt_next == HOLD_LAST) begin
                            long_pulse_reg <= 1'b1;
                            state_reg      <= ST_LONG_HELD;
`ifdef LONG_REPEAT_EN
                            // Start the auto-repeat interval from zero.
                            hold_cnt_reg   <= '0;
`endif
                        end
                    end else begin
                        short_pulse_reg <= 1'b1;
                        state_reg       <= ST_IDLE;
                    end
                end

                ST_LONG_HELD: begin
                    if (!btn_level_reg) begin
                        // The press was already reported by long_pulse.
                        state_reg <= ST_IDLE;
                    end
`ifdef LONG_REPEAT_EN
                    else if (hold_cnt_reg == HOLD_LAST) begin
                        long_pulse_reg <= 1'b1;
                        hold_cnt_reg   <= '0;
                    end else begin
                        hold_cnt_reg   <= hold_cnt_next;
                    end
`endif
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign btn_level   = btn_level_reg;
    assign press_pulse = press_pulse_reg;
    assign short_pulse = short_pulse_reg;
    assign long_pulse  = long_pulse_reg;

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Front-end conditioning stage for each push-button; one instance per button (btn_c, btn_d).
- Sits directly upstream of system_controller.
- Synchronises and debounces the raw pad input, then classifies each press as short or long.
- Emits single-cycle event pulses, so system_controller consumes clean events instead of raw levels.

Parameters:
- DEBOUNCE_COUNT, 1_000_000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- LONG_PRESS_COUNT, 100_000_000, debounced-high cycles that qualify a press as long (1 s at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- btn_raw  input  1  asynchronous button pad input, active-high
- btn_level  output  1  debounced button level
- press_pulse  output  1  one-cycle pulse on debounced rising edge
- short_pulse  output  1  one-cycle pulse on release of a press shorter than LONG_PRESS_COUNT
- long_pulse  output  1  one-cycle pulse when hold reaches LONG_PRESS_COUNT while still pressed

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
  - While reset=1: sync FFs, btn_level, press_pulse, short_pulse and long_pulse are 0; counters are 0; FSM is in IDLE.
- Synchroniser:
  - Two-FF chain on btn_raw produces btn_sync.
  - Latency from btn_raw to btn_sync is 2 cycles.
- Debounce:
  - deb_cnt increments each cycle btn_sync != btn_level, and clears whenever btn_sync == btn_level.
  - When deb_cnt == DEBOUNCE_COUNT-1 with a mismatch, btn_level toggles on the next edge and deb_cnt clears.
  - Result: btn_level follows btn_raw after 2 + DEBOUNCE_COUNT cycles.
  - Any glitch shorter than DEBOUNCE_COUNT cycles is ignored.
- press_pulse: registered as btn_level AND NOT btn_level_d; high for exactly one cycle.
- FSM states: IDLE, PRESSED, LONG_HELD (all pulse outputs registered).
  - IDLE: when btn_level=1, go to PRESSED with hold_cnt=0.
  - PRESSED, btn_level=1: hold_cnt increments. When hold_cnt == LONG_PRESS_COUNT-1, assert long_pulse for one cycle and go to LONG_HELD.
  - PRESSED, btn_level=0: assert short_pulse for one cycle and go to IDLE.
  - LONG_HELD: stay while btn_level=1; go to IDLE on btn_level=0 with no pulse.
- Pulse rules:
  - Exactly one of short_pulse/long_pulse per press, never both.
  - long_pulse fires during the hold, not on release.
- hold_cnt width: $clog2(LONG_PRESS_COUNT+1). It saturates and never wraps.
- Boundaries:
  - Release on the same cycle hold_cnt would reach LONG_PRESS_COUNT-1: release wins, giving short_pulse and no long_pulse.
  - Reset mid-press: all state clears. If the button is still held after reset, it is re-debounced and treated as a new press (press_pulse fires again).
  - Re-press in the cycle immediately after IDLE is re-entered is a valid new press.

Optional Feature:
- Macro: LONG_REPEAT_EN.
- When defined: in LONG_HELD, hold_cnt restarts at 0 and long_pulse re-asserts for one cycle every LONG_PRESS_COUNT cycles while held (auto-repeat).
- When undefined: exactly one long_pulse per press; hold_cnt is frozen in LONG_HELD.

Test Plan (DEBOUNCE_COUNT=4, LONG_PRESS_COUNT=200):
- Glitch: btn_raw high for 3 cycles then low -> btn_level stays 0; no pulses.
- Short press: btn_raw high for 50 cycles -> btn_level rises 6 cycles after the raw edge; press_pulse lasts 1 cycle; short_pulse lasts 1 cycle shortly after btn_level falls; long_pulse stays 0.
- Long press: btn_raw high for 250 cycles -> long_pulse lasts 1 cycle, 200 cycles after btn_level rises; no short_pulse on release; with LONG_REPEAT_EN, no second long_pulse (hold is under 400 cycles).
- Boundary: debounced hold of exactly 199 cycles -> short_pulse; exactly 200 cycles -> long_pulse only.
- Reset mid-press: reset=1 for 10 cycles at cycle 100 of a hold, then released while the button stays high -> outputs 0 during reset; fresh press_pulse follows; long_pulse arrives 200 cycles after the new btn_level rise.
- Auto-repeat (LONG_REPEAT_EN): hold for 700 debounced cycles -> long_pulse at cycles 200, 400 and 600; release produces no short_pulse.
